// File: rtl/img2col_addr_gen_pkg.sv
// img2col_addr_gen_pkg: shared tile geometry, FSM state encoding and span helper.
package img2col_addr_gen_pkg;
  localparam int S2P_SIZE = 2;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int span_of(input int kk);
    return ((kk + S2P_SIZE * S2P_SIZE - 1) / (S2P_SIZE * S2P_SIZE)) * S2P_SIZE * S2P_SIZE;
  endfunction
endpackage

// File: rtl/img2col_win_cnt.sv
// img2col_win_cnt: nested kx/ky/e/ox/oy counters walking windows in img2col order.
module img2col_win_cnt #(
  parameter int KER = 3,
  parameter int SPAN = 12,
  parameter int OH = 4,
  parameter int OW = 4,
  parameter int KW = $clog2(KER + 1),
  parameter int EW = $clog2(SPAN + 1),
  parameter int XW = $clog2(OW + 1),
  parameter int YW = $clog2(OH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  output logic [KW-1:0] kx,
  output logic [KW-1:0] ky,
  output logic [EW-1:0] e,
  output logic [XW-1:0] ox,
  output logic [YW-1:0] oy,
  output logic          last_elem,
  output logic          last_win
);
  localparam int KK = KER * KER;
  assign last_elem = e == EW'(SPAN - 1);
  assign last_win = ox == XW'(OW - 1) && oy == YW'(OH - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {kx, ky, e, ox, oy} <= '0;
    else if (clr) {kx, ky, e, ox, oy} <= '0;
    else if (en) begin
      if (last_elem) begin
        e <= '0;
        kx <= '0;
        ky <= '0;
        ox <= ox == XW'(OW - 1) ? '0 : ox + 1'b1;
        oy <= ox == XW'(OW - 1) ? oy + 1'b1 : oy;
      end else begin
        e <= e + 1'b1;
        // kernel position freezes once the filler tail starts
        if (e < EW'(KK - 1)) begin
          kx <= kx == KW'(KER - 1) ? '0 : kx + 1'b1;
          ky <= kx == KW'(KER - 1) ? ky + 1'b1 : ky;
        end
      end
    end
endmodule

// File: rtl/img2col_addr_gen.sv
// img2col_addr_gen: issues tensor/weight SRAM addresses and zero qualifiers in img2col order,
// each window zero-filled to a multiple of S2P_SIZE**2 elements.
module img2col_addr_gen
  import img2col_addr_gen_pkg::*;
#(
  parameter int IMG_H = 4,
  parameter int IMG_W = 4,
  parameter int KER = 3,
  parameter int PAD = 1,
  parameter int STRIDE = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_go,
  input  logic                             i_hold,
  output logic [$clog2(IMG_H*IMG_W)-1:0]   o_tensor_addr,
  output logic [$clog2(KER*KER)-1:0]       o_weight_addr,
  output logic                             o_start,
  output logic                             o_t_padding_zero,
  output logic                             o_w_padding_zero,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int KK = KER * KER;
  localparam int SPAN = span_of(KK);
  localparam int OH = (IMG_H + 2 * PAD - KER) / STRIDE + 1;
  localparam int OW = (IMG_W + 2 * PAD - KER) / STRIDE + 1;
  localparam int MX = IMG_H > IMG_W ? IMG_H : IMG_W;
  localparam int CW = $clog2(MX + KER + PAD) + 1;
  localparam int TW = $clog2(IMG_H * IMG_W);
  localparam int WW = $clog2(KK);
  localparam int KW = $clog2(KER + 1);
  localparam int EW = $clog2(SPAN + 1);
  localparam int XW = $clog2(OW + 1);
  localparam int YW = $clog2(OH + 1);
  if (OH < 1 || OW < 1) begin : g_bad_geom
    $error("img2col_addr_gen: kernel larger than padded tensor");
  end
  state_t st, st_nxt;
  logic en, fin, last_elem, last_win, real_e, t_vld;
  logic [KW-1:0] kx, ky;
  logic [EW-1:0] e;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic signed [CW-1:0] iy, ix;
  logic [TW-1:0] taddr_c;
  logic [WW-1:0] waddr_c;
  assign en = st == RUN && !i_hold;
  assign fin = en && last_elem && last_win;
  always_comb st_nxt = st == IDLE ? (i_go ? RUN : IDLE) : st == RUN ? (fin ? DONE : RUN) : IDLE;
  img2col_win_cnt #(
    .KER(KER), .SPAN(SPAN), .OH(OH), .OW(OW), .KW(KW), .EW(EW), .XW(XW), .YW(YW)
  ) u_cnt (
    .clk(clk), .rstn(rstn), .clr(st != RUN), .en(en),
    .kx(kx), .ky(ky), .e(e), .ox(ox), .oy(oy),
    .last_elem(last_elem), .last_win(last_win)
  );
  // signed input coordinates; negative or past-edge means border padding
  assign iy = CW'(int'(oy) * STRIDE + int'(ky) - PAD);
  assign ix = CW'(int'(ox) * STRIDE + int'(kx) - PAD);
  assign real_e = e < EW'(KK);
  assign t_vld = real_e && !iy[CW-1] && iy < CW'(IMG_H) && !ix[CW-1] && ix < CW'(IMG_W);
  assign taddr_c = t_vld ? TW'(int'(iy) * IMG_W + int'(ix)) : '0;
  assign waddr_c = real_e ? WW'(int'(ky) * KER + int'(kx)) : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_start <= 1'b0;
      o_tensor_addr <= '0;
      o_weight_addr <= '0;
      o_t_padding_zero <= 1'b0;
      o_w_padding_zero <= 1'b0;
    end else begin
      st <= st_nxt;
      o_busy <= st != IDLE;
      o_done <= st == DONE;
      o_start <= en;
      if (en) begin
        o_tensor_addr <= taddr_c;
        o_weight_addr <= waddr_c;
        o_t_padding_zero <= !t_vld;
        o_w_padding_zero <= !real_e;
      end else if (st != RUN) begin
        o_tensor_addr <= '0;
        o_weight_addr <= '0;
        o_t_padding_zero <= 1'b0;
        o_w_padding_zero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_img2col_addr_gen.sv
// tb_img2col_addr_gen: scoreboard bench; a reference walk of the img2col order is queued per pass.
module tb_img2col_addr_gen;
  localparam int H = 4, W = 4, K = 3, P = 1, S = 1;
  localparam int KK = 9, SPAN = 12, OH = 4, OW = 4, TOTAL = OH * OW * SPAN;
  logic clk = 1'b0, rstn = 1'b0, i_go = 1'b0, i_hold = 1'b0;
  logic [3:0] o_tensor_addr, o_weight_addr;
  logic o_start, o_t_padding_zero, o_w_padding_zero, o_busy, o_done;
  logic [9:0] cur;
  int n_chk = 0, n_err = 0, cnt = 0, n_done = 0, prev = 0;
  int q[$], cap[$];
  bit pass_active = 0, hold_q = 0, prev_start = 0;
  int tp00[12] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1};
  int ta00[12] = '{0, 0, 0, 0, 0, 1, 0, 4, 5, 0, 0, 0};
  int tp33[12] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int ta33[12] = '{10, 11, 0, 14, 15, 0, 0, 0, 0, 0, 0, 0};

  img2col_addr_gen #(.IMG_H(H), .IMG_W(W), .KER(K), .PAD(P), .STRIDE(S)) dut (
    .clk(clk), .rstn(rstn), .i_go(i_go), .i_hold(i_hold),
    .o_tensor_addr(o_tensor_addr), .o_weight_addr(o_weight_addr), .o_start(o_start),
    .o_t_padding_zero(o_t_padding_zero), .o_w_padding_zero(o_w_padding_zero),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  assign cur = {o_tensor_addr, o_weight_addr, o_t_padding_zero, o_w_padding_zero};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int oy, input int ox, input int e);
    int ky, kx, iy, ix, ta, tp;
    if (e >= KK) return 3;
    ky = e / K;
    kx = e % K;
    iy = oy * S + ky - P;
    ix = ox * S + kx - P;
    tp = (iy < 0 || iy >= H || ix < 0 || ix >= W) ? 1 : 0;
    ta = tp != 0 ? 0 : iy * W + ix;
    return (ta << 6) | ((ky * K + kx) << 2) | (tp << 1);
  endfunction

  task automatic load_pass();
    q.delete();
    cap.delete();
    cnt = 0;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int e = 0; e < SPAN; e++) q.push_back(model(oy, ox, e));
    pass_active = 1;
  endtask

  always @(posedge clk) hold_q <= i_hold;

  always @(negedge clk) begin
    if (pass_active && hold_q && cnt < TOTAL) begin
      chk("hold_start", o_start, 0);
      chk("hold_stable", cur, prev);
    end
    if (o_start) begin
      if (q.size() == 0) chk("underflow", q.size(), 1);
      else chk("elem", cur, q.pop_front());
      cap.push_back(cur);
      cnt++;
    end
    if (o_done) begin
      n_done++;
      chk("done_prev_start", prev_start, 1);
      chk("done_count", cnt, TOTAL);
    end
    prev = cur;
    prev_start = o_start;
  end

  task automatic do_pass(input bit rnd_hold, input bit repulse);
    int base, c;
    base = n_done;
    load_pass();
    @(negedge clk); #1; i_go = 1'b1;
    @(negedge clk); #1; i_go = 1'b0;
    c = 0;
    while (n_done == base && c < 4000) begin
      i_hold = rnd_hold && ($urandom_range(0, 2) == 0);
      i_go = repulse && c == 40;
      @(negedge clk); #1;
      c++;
    end
    i_hold = 1'b0;
    i_go = 1'b0;
    chk("done_seen", n_done - base, 1);
    chk("busy_at_done", o_busy, 1);
    @(negedge clk); #1;
    chk("busy_after", o_busy, 0);
    chk("done_pulse", o_done, 0);
    chk("start_total", cnt, TOTAL);
    chk("queue_empty", q.size(), 0);
    pass_active = 0;
  endtask

  initial begin
    int base, c;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", {cur, o_start, o_busy, o_done}, 0);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("idle_busy", o_busy, 0);
    do_pass(0, 0);
    chk("cap_size", cap.size(), TOTAL);
    for (int i = 0; i < 12; i++) begin
      chk("w00_tpad", (cap[i] >> 1) & 1, tp00[i]);
      chk("w00_taddr", cap[i] >> 6, ta00[i]);
      chk("w00_waddr", (cap[i] >> 2) & 15, i < 9 ? i : 0);
      chk("w00_wpad", cap[i] & 1, i >= 9 ? 1 : 0);
      chk("w33_tpad", (cap[180+i] >> 1) & 1, tp33[i]);
      chk("w33_taddr", cap[180+i] >> 6, ta33[i]);
      chk("w33_wpad", cap[180+i] & 1, i >= 9 ? 1 : 0);
    end
    do_pass(1, 0);
    do_pass(0, 1);
    base = n_done;
    load_pass();
    @(negedge clk); #1; i_go = 1'b1;
    @(negedge clk); #1; i_go = 1'b0;
    c = 0;
    while (cnt < 50 && c < 2000) begin
      @(negedge clk); #1;
      c++;
    end
    chk("reach50", cnt, 50);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out", {cur, o_start, o_busy, o_done}, 0);
    pass_active = 0;
    q.delete();
    repeat (3) @(negedge clk);
    #1; rstn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("no_done", n_done - base, 0);
    chk("idle_after_rst", {cur, o_start, o_busy}, 0);
    do_pass(0, 0);
    for (int i = 0; i < 12; i++) chk("w00_again_tpad", (cap[i] >> 1) & 1, tp00[i]);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
